// File: rtl/iccm_arb_pkg.sv
// Shared types and default widths for the ICCM SRAM arbiter.
//   ICCM_AW / ICCM_DW : default SRAM word-address and data widths
//   STARVE_W          : width of the port-1 starvation counter
//   sram_req_t        : one requester's access bundle
package iccm_arb_pkg;

  localparam int unsigned ICCM_AW  = 10;
  localparam int unsigned ICCM_DW  = 32;
  localparam int unsigned ICCM_MW  = ICCM_DW / 8;
  localparam int unsigned STARVE_W = 4;

  typedef struct packed {
    logic               req;
    logic               we;
    logic [ICCM_AW-1:0] addr;
    logic [ICCM_DW-1:0] wdata;
    logic [ICCM_MW-1:0] wmask;
  } sram_req_t;

endpackage

// File: rtl/iccm_arb_grant.sv
// Fixed-priority grant with a starvation limit for port 1.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   lock_i               : program-load lock, masks port 1
//   p0_req_i, p1_req_i   : access requests
//   p0_gnt_o, p1_gnt_o   : combinational one-hot (or zero) grant
module iccm_arb_grant
  import iccm_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  input  logic p0_req_i,
  input  logic p1_req_i,
  output logic p0_gnt_o,
  output logic p1_gnt_o
);

  localparam logic [STARVE_W-1:0] StarveLimit = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                p1_elig;
  logic                starved;

  assign p1_elig  = p1_req_i & ~lock_i;
  assign starved  = (starve_q == StarveLimit);
  assign p1_gnt_o = p1_elig & (~p0_req_i | starved);
  assign p0_gnt_o = p0_req_i & ~p1_gnt_o;

  // Counts consecutive cycles port 1 was eligible but lost; any break
  // (grant, request dropped, lock) restarts the count.
  always_comb begin
    starve_d = '0;
    if (p1_elig && !p1_gnt_o) begin
      starve_d = starved ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/iccm_sram_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency ICCM SRAM.
//   Port 0 : UART program loader (priority)
//   Port 1 : TL-UL instruction-memory adapter (blocked while lock_i)
//   pN_*   : request bundle, grant and read-valid per port
//   rdata_o: shared read data, qualified by pN_rvalid_o
//   mem_*  : SRAM macro interface
module iccm_sram_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int unsigned AW         = ICCM_AW,
  parameter int unsigned DW         = ICCM_DW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lock_i,
  input  logic            p0_req_i,
  input  logic            p0_we_i,
  input  logic [AW-1:0]   p0_addr_i,
  input  logic [DW-1:0]   p0_wdata_i,
  input  logic [DW/8-1:0] p0_wmask_i,
  output logic            p0_gnt_o,
  output logic            p0_rvalid_o,
  input  logic            p1_req_i,
  input  logic            p1_we_i,
  input  logic [AW-1:0]   p1_addr_i,
  input  logic [DW-1:0]   p1_wdata_i,
  input  logic [DW/8-1:0] p1_wmask_i,
  output logic            p1_gnt_o,
  output logic            p1_rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            mem_en_o,
  output logic [DW/8-1:0] mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  // The request bundle carries the package default widths; AW/DW are
  // expected to stay at those defaults.
  sram_req_t p0, p1, win;
  logic [1:0] rd_owner_q, rd_owner_d;

  assign p0 = '{req: p0_req_i, we: p0_we_i, addr: p0_addr_i, wdata: p0_wdata_i,
                wmask: p0_wmask_i};
  assign p1 = '{req: p1_req_i, we: p1_we_i, addr: p1_addr_i, wdata: p1_wdata_i,
                wmask: p1_wmask_i};

  iccm_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .lock_i   (lock_i),
    .p0_req_i (p0.req),
    .p1_req_i (p1.req),
    .p0_gnt_o (p0_gnt_o),
    .p1_gnt_o (p1_gnt_o)
  );

  // Idle cycles leave port 0 on the address/data bus; only en/we matter.
  assign win = p1_gnt_o ? p1 : p0;

  always_comb begin
    mem_en_o    = p0_gnt_o | p1_gnt_o;
    mem_addr_o  = win.addr;
    mem_wdata_o = win.wdata;
    mem_we_o    = '0;
    if (mem_en_o && win.we) begin
      mem_we_o = win.wmask;
    end
  end

  // One-hot owner of the read issued last cycle; bit 0 = port 0.
  always_comb begin
    rd_owner_d = {p1_gnt_o & ~p1_we_i, p0_gnt_o & ~p0_we_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_owner_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign p0_rvalid_o = rd_owner_q[0];
  assign p1_rvalid_o = rd_owner_q[1];
  assign rdata_o     = mem_rdata_i;

endmodule

// File: tb/tb_iccm_sram_arbiter.sv
// Self-checking bench for iccm_sram_arbiter: directed scenarios plus a
// randomized phase, all checked against a behavioural model of the arbiter
// and an array image of the SRAM contents.
module tb_iccm_sram_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [9:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_wmask, p1_wmask;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  iccm_sram_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .lock_i      (lock),
    .p0_req_i    (p0_req),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p0_wmask_i  (p0_wmask),
    .p0_gnt_o    (p0_gnt),
    .p0_rvalid_o (p0_rvalid),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_wmask_i  (p1_wmask),
    .p1_gnt_o    (p1_gnt),
    .p1_rvalid_o (p1_rvalid),
    .rdata_o     (rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro stand-in: 1-cycle read latency, byte write enables.
  logic [31:0] sram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model state
  logic [31:0] exp_mem [1024];
  int          wait_cnt;    // consecutive cycles port 1 was eligible and lost
  logic        pend0, pend1;
  logic [31:0] pend_data;
  logic        obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [31:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance model at the rising edge.
  task automatic cyc(input logic r0, input logic w0, input logic [9:0] a0,
                     input logic [31:0] d0, input logic [3:0] m0,
                     input logic r1, input logic w1, input logic [9:0] a1,
                     input logic [31:0] d1, input logic [3:0] m1, input logic lk);
    logic el, eg0, eg1;
    logic [3:0] ewe;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_wmask = m0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_wmask = m1;
    lock = lk;
    @(negedge clk);
    el  = r1 && !lk;
    eg1 = el && (!r0 || wait_cnt >= STARVE_MAX);
    eg0 = r0 && !eg1;
    ewe = eg1 ? (w1 ? m1 : 4'h0) : (eg0 ? (w0 ? m0 : 4'h0) : 4'h0);
    chk("p0_gnt", p0_gnt, eg0);
    chk("p1_gnt", p1_gnt, eg1);
    chk("mem_en", mem_en, eg0 | eg1);
    chk("mem_we", mem_we, ewe);
    if (eg0 || eg1) chk("mem_addr", mem_addr, eg1 ? a1 : a0);
    if (ewe != 4'h0) chk("mem_wdata", mem_wdata, eg1 ? d1 : d0);
    chk("p0_rvalid", p0_rvalid, pend0);
    chk("p1_rvalid", p1_rvalid, pend1);
    if (pend0 || pend1) chk("rdata", rdata, pend_data);
    obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid;
    obs_rdata = rdata;
    @(posedge clk);
    pend0 = eg0 && !w0;
    pend1 = eg1 && !w1;
    if (pend0) pend_data = exp_mem[a0];
    if (pend1) pend_data = exp_mem[a1];
    if (eg0 && w0) exp_mem[a0] = merge(exp_mem[a0], d0, m0);
    if (eg1 && w1) exp_mem[a1] = merge(exp_mem[a1], d1, m1);
    wait_cnt = (el && !eg1) ? ((wait_cnt < STARVE_MAX) ? wait_cnt + 1 : STARVE_MAX) : 0;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    mem_rdata = 32'h0;
    wait_cnt = 0; pend0 = 0; pend1 = 0; pend_data = 0;
    rst = 1'b1;
    lock = 0; p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wmask = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wmask = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: no grants, no enable, no rvalid.
    repeat (10) idle();

    // Write on port 0, read back on port 1.
    cyc(1, 1, 10'h005, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 10'h005, 0, 0, 0);
    chk("wr_rd_p1_gnt", obs_g1, 1);
    idle();
    chk("wr_rd_p1_rvalid", obs_rv1, 1);
    chk("wr_rd_p0_rvalid", obs_rv0, 0);
    chk("wr_rd_rdata", obs_rdata, 32'hDEADBEEF);

    // Continuous contention: p1 wins every fifth cycle.
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 10'(i), 0, 0, 1, 0, 10'h005, 0, 0, 0);
      chk("starve_pat_p1", obs_g1, logic'(i % 5 == 4));
      chk("starve_pat_p0", obs_g0, logic'(i % 5 != 4));
    end
    idle();

    // Lock blocks p1; release grants immediately with p0 idle.
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 0, 10'h005, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 10'h005, 0, 0, 0);
    chk("unlock_p1_gnt", obs_g1, 1);
    idle();
    // Under lock the wait count must not build up: after release p1 waits full limit.
    for (int i = 0; i < 10; i++) cyc(1, 0, 10'h005, 0, 0, 1, 0, 10'h005, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 10'h005, 0, 0, 1, 0, 10'h005, 0, 0, 0);
      chk("unlock_wait_p1", obs_g1, logic'(i == 4));
    end
    idle();

    // Lock rising with a p1 read outstanding still delivers it.
    cyc(0, 0, 0, 0, 0, 1, 0, 10'h005, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 10'h006, 0, 0, 1);
    chk("lock_rv_p1", obs_rv1, 1);
    chk("lock_rv_data", obs_rdata, 32'hDEADBEEF);
    chk("lock_rv_nognt", obs_g1, 0);
    idle();

    // Partial byte write.
    cyc(1, 1, 10'h009, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 10'h009, 32'h11223344, 4'h5, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 10'h009, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("mask_rdata", obs_rdata, 32'hAA22AA44);
    chk("mask_rvalid", obs_rv0, 1);

    // Asynchronous reset right after a read grant kills the pending rvalid.
    cyc(1, 0, 10'h009, 0, 0, 0, 0, 0, 0, 0, 0);
    p0_req = 0;
    chk("pre_rst_rvalid", p0_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_rvalid_async", p0_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    #2 rst = 1'b0;
    pend0 = 0; pend1 = 0; wait_cnt = 0;
    @(posedge clk); #1;
    idle();
    idle();

    // Randomized traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
          $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 7) == 0));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iccm_sram_arbiter.md
# iccm_sram_arbiter

Arbitrates one single-port, 1-cycle-read-latency instruction SRAM (DFFRAM macro, 1024 × 32, byte write enables) between two requesters. Port 0 is the UART program loader (ICCM controller write path); port 1 is the TL-UL instruction-memory adapter serving core fetch and data accesses. Port 0 has fixed priority, with a starvation limit that guarantees port 1 forward progress. A lock input blocks port 1 entirely while a program load is in progress.

## Interface
- AW, 10, SRAM word-address width
- DW, 32, data width; byte mask width is DW/8
- STARVE_MAX, 4, consecutive lost-contention cycles after which port 1 wins; legal range 1..15
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous and active-high
- lock_i  in  1  program-load lock; while high, port 1 is never granted
- p0_req_i / p1_req_i  in  1  access request; held until granted
- p0_we_i / p1_we_i  in  1  1 = write, 0 = read
- p0_addr_i / p1_addr_i  in  AW  word address
- p0_wdata_i / p1_wdata_i  in  DW  write data
- p0_wmask_i / p1_wmask_i  in  DW/8  byte enables, writes only
- p0_gnt_o / p1_gnt_o  out  1  access accepted this cycle
- p0_rvalid_o / p1_rvalid_o  out  1  read data valid, one cycle after a read grant
- rdata_o  out  DW  SRAM read data, shared by both ports; qualified by rvalid
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  DW/8  SRAM byte write enables (all zero for reads)
- mem_addr_o  out  AW  SRAM address
- mem_wdata_o  out  DW  SRAM write data
- mem_rdata_i  in  DW  SRAM read data, valid the cycle after enable

## Operation
- The grant is combinational from the requests and registered state. At most one port is granted per cycle.
- Port 1 is eligible when `p1_req_i & ~lock_i`.
- Selection:
  - If only one port is requesting and eligible, that port is granted.
  - If both are, port 0 wins unless `starve_q == STARVE_MAX`, in which case port 1 wins.
- `starve_q` (4-bit) update rule:
  - Increments in any cycle where port 1 is eligible and not granted; saturates at STARVE_MAX.
  - Clears on a port-1 grant.
  - Clears when `p1_req_i` is low.
  - Clears when `lock_i` is high.
- Memory drive on a granted cycle:
  - `mem_en_o = 1`.
  - `mem_addr_o` and `mem_wdata_o` come from the winning port.
  - `mem_we_o = we ? wmask : 0`.
- Memory drive with no grant: `mem_en_o = 0`, `mem_we_o = 0`, and address/data hold the port-0 values (don't-care).
- Read return: registered `rd_owner_q` (2-bit one-hot) records which port, if any, was granted a read. The matching `pN_rvalid_o` is asserted the next cycle. `rdata_o = mem_rdata_i`, passed through directly.
- Writes produce no rvalid. A write with mask 0 is granted and consumes a cycle, but writes nothing.
- Back-to-back reads from one or both ports are sustained at one per cycle.
- `lock_i` rising while a port-1 read is outstanding: that read's rvalid is still delivered.
- `lock_i` and `p1_req_i` high together: `p1_gnt_o = 0` and the counter stays at 0.

## Timing
- Reset values (rst_i async, high):
  - `starve_q = 0`, `rd_owner_q = 0`.
  - All gnt and rvalid outputs 0.
  - `mem_en_o = 0`, `mem_we_o = 0`.
- Reset asserted mid-read clears the pending rvalid; no rvalid is produced after reset.
- Grant latency is 0 cycles when a request is not contended.
- Read data latency is exactly 1 cycle after the grant.
- Worst-case port-1 wait under continuous port-0 traffic, lock low, is STARVE_MAX cycles; the grant comes on cycle STARVE_MAX+1.
- No combinational path from `mem_rdata_i` to any gnt output.

## Structure
- Shared package `iccm_arb_pkg`:
  - `sram_req_t` struct: req, we, addr, wdata, wmask.
  - Default widths AW and DW.
  - STARVE_W = 4.
- One sub-module, `iccm_arb_grant`: the priority/starvation grant logic and `starve_q`. The top level holds the memory mux and `rd_owner_q`.

## Test plan
- Reset then idle → all outputs 0; `mem_en_o = 0` for 10 cycles.
- p0 write addr 0x005, wdata 0xDEADBEEF, mask 0xF; next cycle p1 read addr 0x005 → `p1_gnt_o` asserted; one cycle later `p1_rvalid_o = 1` and `rdata_o = 0xDEADBEEF`, with `p0_rvalid_o = 0`.
- Both ports request reads continuously, STARVE_MAX = 4, lock low → grants repeat the pattern p0,p0,p0,p0,p1 with period 5. Each rvalid appears one cycle after its own grant.
- lock high, p1 requests continuously for 20 cycles, p0 idle → `p1_gnt_o` stays 0 and `starve_q` stays 0. Lock drops → p1 is granted in that same cycle.
- p1 read granted at cycle N, lock rises at N+1 → `p1_rvalid_o = 1` at N+1 with the correct data.
- p0 write with mask 0b0101, data 0x11223344, over a word holding 0xAAAAAAAA; then read it back → 0xAA22AA44.
- rst_i pulsed in the cycle after a read grant → rvalid stays 0; state returns to reset values asynchronously.
